// File: rtl/hazard_stall_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_scheduler
// Description : Decode-stage interlock for the 5-stage MIPS pipeline. It covers
//               load-use, branch-compare (HAZARD_BRANCH_FREEZE_EN) and mul/div
//               hazards, and it sequences the multi-cycle mul/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_scheduler #(
  parameter int MULDIV_LAT = 8,
  parameter int CNT_W      = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ID_Valid,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRs,
  input  logic       ID_UsesRt,
  input  logic [4:0] ID_DestReg,
  input  logic       ID_RegWrite,
  input  logic       ID_MemRead,
  input  logic       ID_Branch,
  input  logic       ID_MulDiv,
  input  logic       ID_HiLoRead,
  input  logic       PIPE_FREEZE,
  output logic       STALL_IFID,
  output logic       BUBBLE_EX,
  output logic       MD_START,
  output logic       MD_BUSY,
  output logic [2:0] STALL_CAUSE
);

  localparam logic [0:0]       S_IDLE = 1'b0;
  localparam logic [0:0]       S_RUN  = 1'b1;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MULDIV_LAT - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       ex_dest_q, ex_dest_d, mem_dest_q;
  logic             ex_load_q, ex_load_d, mem_load_q;

  logic             lu_stall, br_stall, md_stall, any_stall, md_launch;

  // Register 0 is never a producer, so a zero destination can never match.
  assign lu_stall = ID_Valid & ex_load_q & (ex_dest_q != 5'd0) &
                    ((ID_UsesRs & (ID_Rs == ex_dest_q)) |
                     (ID_UsesRt & (ID_Rt == ex_dest_q)));

`ifdef HAZARD_BRANCH_FREEZE_EN
  logic rs_pend, rt_pend;
  // The comparator in ID sees neither EX results nor loads still in MEM.
  assign rs_pend = ((ex_dest_q != 5'd0) & (ID_Rs == ex_dest_q)) |
                   ((mem_dest_q != 5'd0) & mem_load_q & (ID_Rs == mem_dest_q));
  assign rt_pend = ((ex_dest_q != 5'd0) & (ID_Rt == ex_dest_q)) |
                   ((mem_dest_q != 5'd0) & mem_load_q & (ID_Rt == mem_dest_q));
  assign br_stall = ID_Valid & ID_Branch &
                    ((ID_UsesRs & rs_pend) | (ID_UsesRt & rt_pend));
`else
  logic unused_br;
  assign unused_br = ^{ID_Branch, mem_dest_q, mem_load_q};
  assign br_stall  = 1'b0;
`endif

  assign md_stall  = (state_q == S_RUN) & ID_Valid & (ID_HiLoRead | ID_MulDiv);
  assign any_stall = lu_stall | br_stall | md_stall;
  assign md_launch = (state_q == S_IDLE) & ID_Valid & ID_MulDiv &
                     ~any_stall & ~PIPE_FREEZE;

  // Outputs are gated by the asynchronous reset so they drop without an edge.
  assign STALL_IFID  = any_stall & RESET;
  assign BUBBLE_EX   = any_stall & RESET;
  assign MD_START    = md_launch & RESET;
  assign MD_BUSY     = (state_q == S_RUN) & RESET;
  assign STALL_CAUSE = {md_stall, br_stall, lu_stall} & {3{RESET}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (md_launch) begin
          state_d = S_RUN;
          cnt_d   = LAT_M1;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The mul/div unit keeps counting through a pipeline freeze.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ex_dest_d = 5'd0;
    ex_load_d = 1'b0;
    if (ID_Valid && !any_stall) begin
      ex_dest_d = ID_RegWrite ? ID_DestReg : 5'd0;
      ex_load_d = ID_MemRead;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ex_dest_q  <= 5'd0;
      ex_load_q  <= 1'b0;
      mem_dest_q <= 5'd0;
      mem_load_q <= 1'b0;
    end else if (!PIPE_FREEZE) begin
      mem_dest_q <= ex_dest_q;
      mem_load_q <= ex_load_q;
      ex_dest_q  <= ex_dest_d;
      ex_load_q  <= ex_load_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_scheduler
// Description : Directed-vector bench with a queue-based scoreboard for
//               hazard_stall_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_scheduler;

`ifdef HAZARD_BRANCH_FREEZE_EN
  localparam logic BR_EN = 1'b1;
`else
  localparam logic BR_EN = 1'b0;
`endif

  logic       CLK, RESET;
  logic       ID_Valid, ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead;
  logic       ID_Branch, ID_MulDiv, ID_HiLoRead, PIPE_FREEZE;
  logic [4:0] ID_Rs, ID_Rt, ID_DestReg;
  logic       STALL_IFID, BUBBLE_EX, MD_START, MD_BUSY;
  logic [2:0] STALL_CAUSE;

  hazard_stall_scheduler #(.MULDIV_LAT(8), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_DestReg(ID_DestReg), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_Branch(ID_Branch),
    .ID_MulDiv(ID_MulDiv), .ID_HiLoRead(ID_HiLoRead),
    .PIPE_FREEZE(PIPE_FREEZE),
    .STALL_IFID(STALL_IFID), .BUBBLE_EX(BUBBLE_EX),
    .MD_START(MD_START), .MD_BUSY(MD_BUSY), .STALL_CAUSE(STALL_CAUSE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    string      nm;
    logic       stall;
    logic       start;
    logic       busy;
    logic [2:0] cause;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_vec  = 0;
  int   n_miss = 0;

  // Monitor: one expectation per driven cycle, checked mid-cycle.
  always @(negedge CLK) begin
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_vec++;
      if ({STALL_IFID, BUBBLE_EX, MD_START, MD_BUSY, STALL_CAUSE} !==
          {e.stall, e.stall, e.start, e.busy, e.cause}) begin
        n_miss++;
        $display("FAIL %s: got stall=%b bubble=%b start=%b busy=%b cause=%b, want stall=%b bubble=%b start=%b busy=%b cause=%b",
                 e.nm, STALL_IFID, BUBBLE_EX, MD_START, MD_BUSY, STALL_CAUSE,
                 e.stall, e.stall, e.start, e.busy, e.cause);
      end
    end
  end

  task automatic drv(input logic v, input logic [4:0] rs, input logic urs,
                     input logic [4:0] rt, input logic urt,
                     input logic [4:0] dst, input logic rw, input logic mr,
                     input logic br, input logic md, input logic hl);
    ID_Valid = v;   ID_Rs = rs;       ID_UsesRs = urs;
    ID_Rt = rt;     ID_UsesRt = urt;  ID_DestReg = dst;
    ID_RegWrite = rw; ID_MemRead = mr; ID_Branch = br;
    ID_MulDiv = md; ID_HiLoRead = hl;
  endtask

  task automatic i_nop();                      drv(0,0,0,0,0,0,0,0,0,0,0);       endtask
  task automatic i_lw(input logic [4:0] rt, input logic [4:0] rs);
                                               drv(1,rs,1,rt,0,rt,1,1,0,0,0);     endtask
  task automatic i_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
                                               drv(1,rs,1,rt,1,rd,1,0,0,0,0);     endtask
  task automatic i_beq(input logic [4:0] rs, input logic [4:0] rt);
                                               drv(1,rs,1,rt,1,0,0,0,1,0,0);      endtask
  task automatic i_mult(input logic [4:0] rs, input logic [4:0] rt);
                                               drv(1,rs,1,rt,1,0,0,0,0,1,0);      endtask
  task automatic i_mfhi(input logic [4:0] rd); drv(1,0,0,0,0,rd,1,0,0,0,1);       endtask

  task automatic step(input string nm, input logic s, input logic st,
                      input logic b, input logic [2:0] c);
    exp_t x;
    x.nm = nm; x.stall = s; x.start = st; x.busy = b; x.cause = c;
    sbq.push_back(x);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b0;
    PIPE_FREEZE = 1'b0;
    i_nop();
    @(posedge CLK);
    #1;
    // A valid mult during reset must not launch anything.
    i_mult(5'd1, 5'd2);
    step("reset", 0, 0, 0, 3'b000);
    RESET = 1'b1;

    // Load-use, rs and rt operands, $0 and invalid-slot cases
    i_lw(5'd5, 5'd1);        step("lw5", 0, 0, 0, 3'b000);
    i_add(5'd6, 5'd5, 5'd7); step("lu_rs", 1, 0, 0, 3'b001);
    i_add(5'd6, 5'd5, 5'd7); step("lu_rs_go", 0, 0, 0, 3'b000);
    i_lw(5'd5, 5'd1);        step("lw5b", 0, 0, 0, 3'b000);
    i_add(5'd6, 5'd8, 5'd7); step("lu_nomatch", 0, 0, 0, 3'b000);
    i_lw(5'd0, 5'd1);        step("lw0", 0, 0, 0, 3'b000);
    i_add(5'd6, 5'd0, 5'd0); step("lu_r0", 0, 0, 0, 3'b000);
    i_lw(5'd9, 5'd1);        step("lw9", 0, 0, 0, 3'b000);
    i_add(5'd10, 5'd1, 5'd9); step("lu_rt", 1, 0, 0, 3'b001);
    i_add(5'd10, 5'd1, 5'd9); step("lu_rt_go", 0, 0, 0, 3'b000);
    i_lw(5'd4, 5'd1);        step("lw4", 0, 0, 0, 3'b000);
    i_add(5'd2, 5'd4, 5'd4); ID_Valid = 1'b0;
                             step("lu_invalid", 0, 0, 0, 3'b000);
    i_add(5'd2, 5'd4, 5'd0); step("after_invalid", 0, 0, 0, 3'b000);

    // Mul/div: launch, mfhi waits the full latency
    i_mult(5'd1, 5'd2);      step("mult1", 0, 1, 0, 3'b000);
    i_mfhi(5'd3);
    for (int i = 0; i < 8; i++) step("mfhi_wait", 1, 0, 1, 3'b100);
    step("mfhi_go", 0, 0, 0, 3'b000);
    i_mult(5'd1, 5'd2);      step("mult2", 0, 1, 0, 3'b000);
    i_mult(5'd4, 5'd5);
    for (int i = 0; i < 8; i++) step("mult_wait", 1, 0, 1, 3'b100);
    step("mult3", 0, 1, 0, 3'b000);

    // Freeze during RUN: counter runs on, shadows hold
    i_lw(5'd5, 5'd1);        step("run_lw", 0, 0, 1, 3'b000);
    i_add(5'd6, 5'd5, 5'd7); PIPE_FREEZE = 1'b1;
    for (int i = 0; i < 3; i++) step("frz_lu", 1, 0, 1, 3'b001);
    PIPE_FREEZE = 1'b0;      step("frz_rel_lu", 1, 0, 1, 3'b001);
                             step("frz_lu_go", 0, 0, 1, 3'b000);
    i_nop();                 step("run_tail", 0, 0, 1, 3'b000);
                             step("run_last", 0, 0, 1, 3'b000);

    // MD_START suppressed by load-use stall and by freeze
    i_lw(5'd7, 5'd1);        step("idle_lw7", 0, 0, 0, 3'b000);
    i_mult(5'd7, 5'd1);      PIPE_FREEZE = 1'b1;
                             step("md_lu_frz", 1, 0, 0, 3'b001);
    PIPE_FREEZE = 1'b0;      step("md_lu", 1, 0, 0, 3'b001);
    PIPE_FREEZE = 1'b1;      step("md_frz", 0, 0, 0, 3'b000);
    PIPE_FREEZE = 1'b0;      step("md_go", 0, 1, 0, 3'b000);

    // Asynchronous reset mid-RUN with a pending stall
    i_mfhi(5'd3);            step("pre_rst", 1, 0, 1, 3'b100);
    RESET = 1'b0;            step("mid_rst", 0, 0, 0, 3'b000);
    RESET = 1'b1;            step("post_rst", 0, 0, 0, 3'b000);

    // Branch compare in ID
    i_add(5'd3, 5'd1, 5'd2); step("br_add", 0, 0, 0, 3'b000);
    i_beq(5'd3, 5'd4);       step("br_alu", BR_EN, 0, 0, {1'b0, BR_EN, 1'b0});
                             step("br_alu_go", 0, 0, 0, 3'b000);
    i_lw(5'd3, 5'd1);        step("br_lw", 0, 0, 0, 3'b000);
    i_beq(5'd3, 5'd4);       step("br_load1", 1, 0, 0, {1'b0, BR_EN, 1'b1});
                             step("br_load2", BR_EN, 0, 0, {1'b0, BR_EN, 1'b0});
                             step("br_load_go", 0, 0, 0, 3'b000);

    i_nop();
    for (int i = 0; i < 3 && sbq.size() > 0; i++) @(posedge CLK);
    if (sbq.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
